// File: rtl/uart_sample_seq.sv
// uart_sample_seq: assembles RX byte pairs into DATA_W-bit samples and splits results into TX byte pairs.
module uart_sample_seq #(
    parameter int DATA_W = 11,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cr_rst,
    input  logic              cr_en,
    input  logic              cr_src_sel,
    input  logic              rx_empty,
    input  logic [7:0]        rx_data,
    output logic              rx_rd,
    input  logic              din_wr,
    input  logic [DATA_W-1:0] din_data,
    output logic [DATA_W-1:0] smp_data,
    output logic              smp_vld,
    input  logic              smp_rdy,
    input  logic [DATA_W-1:0] res_data,
    input  logic              res_vld,
    output logic              res_rdy,
    input  logic              tx_full,
    output logic [7:0]        tx_data,
    output logic              tx_wr,
    output logic              busy,
    output logic              err_fmt,
    output logic              din_ovf,
    output logic [CNT_W-1:0]  cnt_in,
    output logic [CNT_W-1:0]  cnt_out
);
    typedef enum logic [1:0] {R_LO, R_HI, R_OUT} r_t;
    typedef enum logic [1:0] {T_IDLE, T_LO, T_HI} t_t;
    r_t                r_q, r_d;
    t_t                t_q, t_d;
    logic [DATA_W-1:0] smp_q, smp_d;
    logic [DATA_W-9:0] hi_q, hi_d;
    logic [7:0]        tx_q, tx_d;
    logic [CNT_W-1:0]  cnt_in_q, cnt_in_d, cnt_out_q, cnt_out_d;
    logic              err_q, err_d, ovf_q, ovf_d;
    logic              clr, hi_ok, din_acc, res_acc;
    assign clr     = rst | cr_rst;
    assign hi_ok   = (rx_data >> (DATA_W - 8)) == 8'd0;
    assign din_acc = r_q == R_LO && cr_en && cr_src_sel && din_wr;
    assign res_acc = res_rdy && res_vld;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q       <= R_LO;
            t_q       <= T_IDLE;
            smp_q     <= '0;
            hi_q      <= '0;
            tx_q      <= '0;
            cnt_in_q  <= '0;
            cnt_out_q <= '0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            r_q       <= r_d;
            t_q       <= t_d;
            smp_q     <= smp_d;
            hi_q      <= hi_d;
            tx_q      <= tx_d;
            cnt_in_q  <= cnt_in_d;
            cnt_out_q <= cnt_out_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
        end
    end
    always_comb begin
        r_d = r_q;
        t_d = t_q;
        case (r_q)
            R_LO:    if (cr_en && (cr_src_sel ? din_wr : !rx_empty)) r_d = cr_src_sel ? R_OUT : R_HI;
            R_HI:    if (!rx_empty) r_d = hi_ok ? R_OUT : R_LO;
            R_OUT:   if (smp_rdy) r_d = R_LO;
            default: r_d = R_LO;
        endcase
        case (t_q)
            T_IDLE:  if (cr_en && res_vld) t_d = T_LO;
            T_LO:    if (!tx_full) t_d = T_HI;
            T_HI:    if (!tx_full) t_d = T_IDLE;
            default: t_d = T_IDLE;
        endcase
        if (cr_rst) begin
            r_d = R_LO;
            t_d = T_IDLE;
        end
    end
    // Handshake strobes are combinational, so either reset must mask them directly.
    always_comb begin
        rx_rd   = !clr && !rx_empty && ((r_q == R_LO && cr_en && !cr_src_sel) || r_q == R_HI);
        smp_vld = !clr && r_q == R_OUT;
        res_rdy = !clr && t_q == T_IDLE && cr_en;
        tx_wr   = !clr && !tx_full && (t_q == T_LO || t_q == T_HI);
    end
    always_comb begin
        smp_d     = cr_rst ? '0 : din_acc ? din_data
                  : (rx_rd && r_q == R_LO) ? {smp_q[DATA_W-1:8], rx_data}
                  : (rx_rd && hi_ok) ? {rx_data[DATA_W-9:0], smp_q[7:0]} : smp_q;
        hi_d      = cr_rst ? '0 : res_acc ? res_data[DATA_W-1:8] : hi_q;
        tx_d      = cr_rst ? '0 : res_acc ? res_data[7:0] : (tx_wr && t_q == T_LO) ? 8'(hi_q) : tx_q;
        cnt_in_d  = cr_rst ? '0 : cnt_in_q + CNT_W'(smp_vld && smp_rdy);
        cnt_out_d = cr_rst ? '0 : cnt_out_q + CNT_W'(tx_wr && t_q == T_HI);
        err_d     = rx_rd && r_q == R_HI && !hi_ok;
        ovf_d     = !cr_rst && din_wr && !din_acc;
    end
    assign smp_data = smp_q;
    assign tx_data  = tx_q;
    assign cnt_in   = cnt_in_q;
    assign cnt_out  = cnt_out_q;
    assign err_fmt  = err_q;
    assign din_ovf  = ovf_q;
    assign busy     = r_q != R_LO || t_q != T_IDLE;
endmodule
